// File: rtl/cpu_bus_pkg.sv
// Shared types for the single-bus transfer engine: command opcodes, FSM states
// and the register-index width helper.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        OP_MOVE  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XFER,
        ST_ADDR,
        ST_DATA,
        ST_REQ,
        ST_WB,
        ST_DONE
    } state_e;

    // A single-register bank still needs a 1-bit index field.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gp_reg_bank.sv
// General register bank: one write port, two combinational read ports,
// synchronous active-low clear, optional hard-wired zero R0.
module gp_reg_bank
    import cpu_bus_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 32,
    parameter int R0_ZERO  = 0,
    parameter int IDX_W    = idx_w(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [IDX_W-1:0]  ridx_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam logic [IDX_W:0] NREGS = NUM_REGS[IDX_W:0];

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Out-of-range indices and a zero-wired R0 behave as a constant-0 location.
    function automatic logic usable(input logic [IDX_W-1:0] i);
        return ({1'b0, i} < NREGS) && !((R0_ZERO != 0) && (i == '0));
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && usable(widx)) begin
            regs[widx] <= wdata;
        end
    end

    assign rdata_a = usable(ridx_a) ? regs[ridx_a] : '0;
    assign rdata_b = usable(ridx_b) ? regs[ridx_b] : '0;

endmodule

// File: rtl/bus_xfer_engine.sv
// Command-driven single-bus datapath: register moves/clears and memory
// load/store through MAR/MDR over a req/ack memory port.
module bus_xfer_engine
    import cpu_bus_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 16,
    parameter int TIMEOUT  = 255,
    parameter int R0_ZERO  = 0,
    localparam int IDX_W   = idx_w(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [IDX_W-1:0]  cmd_ra,
    input  logic [IDX_W-1:0]  cmd_rb,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic [IDX_W-1:0]  dbg_idx,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] bus_dbg
);

    localparam int              CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]  NREGS = NUM_REGS[IDX_W:0];

    state_e            state, next;
    op_e               op_q, cmd_op_e;
    logic [IDX_W-1:0]  ra_q, rb_q, rd_idx;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr, bus, rd_data;
    logic [CNT_W-1:0]  cnt;
    logic              err_q, bad, reg_we;

    assign cmd_op_e  = op_e'(cmd_op);
    assign bad       = !(({1'b0, cmd_ra} < NREGS) && ({1'b0, cmd_rb} < NREGS));
    assign mem_addr  = mar;
    assign mem_wdata = mdr;
    assign bus_dbg   = bus;

    gp_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .R0_ZERO  (R0_ZERO),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .we      (reg_we),
        .widx    (ra_q),
        .wdata   (bus),
        .ridx_a  (rd_idx),
        .rdata_a (rd_data),
        .ridx_b  (dbg_idx),
        .rdata_b (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            ST_IDLE: if (cmd_valid) begin
                if (bad)                                              next = ST_DONE;
                else if (cmd_op_e == OP_MOVE || cmd_op_e == OP_CLEAR) next = ST_XFER;
                else                                                  next = ST_ADDR;
            end
            ST_XFER: next = ST_DONE;
            ST_ADDR: next = (op_q == OP_STORE) ? ST_DATA : ST_REQ;
            ST_DATA: next = ST_REQ;
            ST_REQ: begin
                if (mem_ack)          next = (op_q == OP_LOAD) ? ST_WB : ST_DONE;
                else if (cnt == LAST) next = ST_DONE;
            end
            ST_WB:   next = ST_DONE;
            ST_DONE: next = ST_IDLE;
            default: next = ST_IDLE;
        endcase
    end

    // Exactly one bus source per state; the bank always reads rb except in DATA.
    always_comb begin
        cmd_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        reg_we    = 1'b0;
        rd_idx    = rb_q;
        bus       = '0;
        case (state)
            ST_IDLE: cmd_ready = 1'b1;
            ST_XFER: begin
                bus    = (op_q == OP_CLEAR) ? '0 : rd_data;
                reg_we = 1'b1;
            end
            ST_ADDR: bus = rd_data;
            ST_DATA: begin
                rd_idx = ra_q;
                bus    = rd_data;
            end
            ST_REQ: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OP_STORE);
                bus     = (op_q == OP_STORE) ? mdr : mem_rdata;
            end
            ST_WB: begin
                bus    = mdr;
                reg_we = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    // A timed-out request leaves MDR untouched; only the error flag is raised.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q  <= OP_MOVE;
            ra_q  <= '0;
            rb_q  <= '0;
            mar   <= '0;
            mdr   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    op_q  <= cmd_op_e;
                    ra_q  <= cmd_ra;
                    rb_q  <= cmd_rb;
                    err_q <= bad;
                end
                ST_ADDR: begin
                    mar <= bus[ADDR_W-1:0];
                    cnt <= '0;
                end
                ST_DATA: begin
                    mdr <= bus;
                    cnt <= '0;
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        if (op_q == OP_LOAD) mdr <= bus;
                    end else if (cnt == LAST) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_xfer_engine.sv
// Self-checking bench: two engine instances (16 regs / TIMEOUT 4, and
// 12 regs / TIMEOUT 6 / zero R0) checked against a command-level model.
module tb_bus_xfer_engine;
    import cpu_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset, sel, cmd_valid, mem_ack;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_ra, cmd_rb, dbg_idx;
    logic [31:0] mem_rdata;

    logic        m_ready, m_done, m_err, m_req, m_we;
    logic        s_ready, s_done, s_err, s_req, s_we;
    logic [15:0] m_addr, s_addr;
    logic [31:0] m_wdata, m_dbg, m_bus, s_wdata, s_dbg, s_bus;

    logic        cur_ready, cur_done, cur_err, cur_req, cur_we;
    logic [15:0] cur_addr;
    logic [31:0] cur_wdata, cur_dbg, cur_bus;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mreg [2][16];
    logic [31:0] mem [logic [15:0]];

    always #5 clk = ~clk;

    bus_xfer_engine #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(16), .TIMEOUT(4), .R0_ZERO(0)) u_main (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid & ~sel), .cmd_ready(m_ready),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .done(m_done), .err(m_err),
        .mem_req(m_req), .mem_we(m_we), .mem_addr(m_addr), .mem_wdata(m_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_idx(dbg_idx), .dbg_data(m_dbg),
        .bus_dbg(m_bus)
    );

    bus_xfer_engine #(.DATA_W(32), .NUM_REGS(12), .ADDR_W(16), .TIMEOUT(6), .R0_ZERO(1)) u_small (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid & sel), .cmd_ready(s_ready),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .done(s_done), .err(s_err),
        .mem_req(s_req), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_idx(dbg_idx), .dbg_data(s_dbg),
        .bus_dbg(s_bus)
    );

    assign cur_ready = sel ? s_ready : m_ready;
    assign cur_done  = sel ? s_done  : m_done;
    assign cur_err   = sel ? s_err   : m_err;
    assign cur_req   = sel ? s_req   : m_req;
    assign cur_we    = sel ? s_we    : m_we;
    assign cur_addr  = sel ? s_addr  : m_addr;
    assign cur_wdata = sel ? s_wdata : m_wdata;
    assign cur_dbg   = sel ? s_dbg   : m_dbg;
    assign cur_bus   = sel ? s_bus   : m_bus;

    // Memory contents: explicit writes, otherwise an address-derived pattern.
    function automatic logic [31:0] mem_val(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return {a ^ 16'h5A3C, ~a};
    endfunction

    function automatic int nregs(input int s);
        return (s == 1) ? 12 : 16;
    endfunction

    function automatic logic [31:0] mrd(input int s, input int i);
        if (i >= nregs(s) || (s == 1 && i == 0)) return 32'h0;
        return mreg[s][i];
    endfunction

    function automatic void mwr(input int s, input int i, input logic [31:0] v);
        if (!(s == 1 && i == 0)) mreg[s][i] = v;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++) mreg[s][i] = 32'h0;
    endfunction

    // Command-level reference: outcome, latency (edge of acceptance to done) and request shape.
    task automatic model_cmd(input int s, input logic [1:0] op, input int ra, input int rb,
                             input int delay, output int lat, output logic err, output int reqs,
                             output logic [15:0] addr, output logic [31:0] wdata);
        int          tmo;
        logic [31:0] v;
        tmo   = (s == 1) ? 6 : 4;
        lat   = 0;
        err   = 1'b0;
        reqs  = 0;
        addr  = 16'h0;
        wdata = 32'h0;
        if (ra >= nregs(s) || rb >= nregs(s)) begin
            lat = 1;
            err = 1'b1;
        end else if (op == OP_MOVE) begin
            mwr(s, ra, mrd(s, rb));
            lat = 2;
        end else if (op == OP_CLEAR) begin
            mwr(s, ra, 32'h0);
            lat = 2;
        end else begin
            v    = mrd(s, rb);
            addr = v[15:0];
            if (op == OP_STORE) wdata = mrd(s, ra);
            if (delay < 0 || delay >= tmo) begin
                err  = 1'b1;
                reqs = tmo;
                lat  = (op == OP_STORE) ? 3 + tmo : 2 + tmo;
            end else begin
                reqs = delay + 1;
                lat  = 4 + delay;
                if (op == OP_STORE) mem[addr] = wdata;
                else                mwr(s, ra, mem_val(addr));
            end
        end
    endtask

    // Issues one command and plays the memory side; ack after 'delay' idle REQ cycles, never if < 0.
    task automatic do_cmd(input logic [1:0] op, input int ra, input int rb, input int delay,
                          output int lat, output logic err_o, output int reqs,
                          output logic [15:0] addr, output logic we, output logic [31:0] wdata,
                          output logic done_after, output logic ready_before);
        @(negedge clk);
        ready_before = cur_ready;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ra    = 4'(ra);
        cmd_rb    = 4'(rb);
        @(posedge clk);
        lat = -1; err_o = 1'b0; reqs = 0; addr = 16'h0; we = 1'b0; wdata = 32'h0;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (cur_done) begin
                lat   = k;
                err_o = cur_err;
            end else if (cur_req) begin
                if (reqs == 0) begin
                    addr  = cur_addr;
                    we    = cur_we;
                    wdata = cur_wdata;
                end
                reqs++;
                if (delay >= 0 && reqs == delay + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_val(cur_addr);
                end
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
            end
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        mem_ack    = 1'b0;
        done_after = cur_done;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            n_checks++; if (cur_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready[%0d]: got %b expected 1", s, cur_ready); end
            n_checks++; if (cur_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req[%0d]: got %b expected 0", s, cur_req); end
            n_checks++; if ({cur_done, cur_err, cur_we} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags[%0d]: got %b expected 000", s, {cur_done, cur_err, cur_we}); end
            n_checks++; if (cur_bus !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_bus[%0d]: got %h expected 0", s, cur_bus); end
            for (int i = 0; i < 16; i++) begin
                dbg_idx = 4'(i);
                #1;
                n_checks++; if (cur_dbg !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_dbg[%0d][%0d]: got %h expected 0", s, i, cur_dbg); end
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_directed;
        logic [1:0]  ops [6] = '{OP_LOAD, OP_LOAD, OP_MOVE, OP_LOAD, OP_STORE, OP_MOVE};
        int          ras [6] = '{2, 3, 5, 7, 7, 3};
        int          rbs [6] = '{0, 0, 3, 2, 2, 3};
        int          dls [6] = '{0, 1, 0, 3, 0, 0};
        int          lat_e, reqs_e, lat_o, reqs_o;
        logic        err_e, err_o, we_o, dn_o, rdy_o;
        logic [15:0] addr_e, addr_o;
        logic [31:0] wd_e, wd_o;
        sel = 1'b0;
        mem[16'h0000] = 32'h0000_0040;
        mem[16'h0040] = 32'h1234_5678;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) mem[16'h0000] = 32'hDEAD_BEEF;
            model_cmd(0, ops[i], ras[i], rbs[i], dls[i], lat_e, err_e, reqs_e, addr_e, wd_e);
            do_cmd(ops[i], ras[i], rbs[i], dls[i], lat_o, err_o, reqs_o, addr_o, we_o, wd_o, dn_o, rdy_o);
            n_checks++; if (rdy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL dir%0d ready: got %b expected 1", i, rdy_o); end
            n_checks++; if (lat_o != lat_e) begin n_fail++; $display("[TB] FAIL dir%0d latency: got %0d expected %0d", i, lat_o, lat_e); end
            n_checks++; if (err_o !== err_e) begin n_fail++; $display("[TB] FAIL dir%0d err: got %b expected %b", i, err_o, err_e); end
            n_checks++; if (reqs_o != reqs_e) begin n_fail++; $display("[TB] FAIL dir%0d req_cycles: got %0d expected %0d", i, reqs_o, reqs_e); end
            n_checks++; if (dn_o !== 1'b0) begin n_fail++; $display("[TB] FAIL dir%0d done_pulse: got %b expected 0", i, dn_o); end
            if (reqs_e > 0) begin
                n_checks++; if (addr_o !== addr_e) begin n_fail++; $display("[TB] FAIL dir%0d addr: got %h expected %h", i, addr_o, addr_e); end
                n_checks++; if (we_o !== (ops[i] == OP_STORE)) begin n_fail++; $display("[TB] FAIL dir%0d we: got %b expected %b", i, we_o, ops[i] == OP_STORE); end
                if (ops[i] == OP_STORE) begin
                    n_checks++; if (wd_o !== wd_e) begin n_fail++; $display("[TB] FAIL dir%0d wdata: got %h expected %h", i, wd_o, wd_e); end
                end
            end
            for (int r = 0; r < 16; r++) begin
                dbg_idx = 4'(r);
                #1;
                n_checks++; if (cur_dbg !== mrd(0, r)) begin n_fail++; $display("[TB] FAIL dir%0d R%0d: got %h expected %h", i, r, cur_dbg, mrd(0, r)); end
            end
        end
        n_checks++; if (mrd(0, 5) !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL dir model R5: got %h expected deadbeef", mrd(0, 5)); end
    endtask

    task automatic test_timeout;
        logic [1:0]  ops [3] = '{OP_LOAD, OP_STORE, OP_LOAD};
        int          ras [3] = '{9, 7, 10};
        int          rbs [3] = '{2, 3, 2};
        int          dls [3] = '{-1, -1, 4};
        int          lat_e, reqs_e, lat_o, reqs_o;
        logic        err_e, err_o, we_o, dn_o, rdy_o;
        logic [15:0] addr_e, addr_o;
        logic [31:0] wd_e, wd_o;
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model_cmd(0, ops[i], ras[i], rbs[i], dls[i], lat_e, err_e, reqs_e, addr_e, wd_e);
            do_cmd(ops[i], ras[i], rbs[i], dls[i], lat_o, err_o, reqs_o, addr_o, we_o, wd_o, dn_o, rdy_o);
            n_checks++; if (lat_o != lat_e) begin n_fail++; $display("[TB] FAIL tmo%0d latency: got %0d expected %0d", i, lat_o, lat_e); end
            n_checks++; if (err_o !== err_e) begin n_fail++; $display("[TB] FAIL tmo%0d err: got %b expected %b", i, err_o, err_e); end
            n_checks++; if (reqs_o != reqs_e) begin n_fail++; $display("[TB] FAIL tmo%0d req_cycles: got %0d expected %0d", i, reqs_o, reqs_e); end
            n_checks++; if (addr_o !== addr_e) begin n_fail++; $display("[TB] FAIL tmo%0d addr: got %h expected %h", i, addr_o, addr_e); end
            n_checks++; if (dn_o !== 1'b0) begin n_fail++; $display("[TB] FAIL tmo%0d done_pulse: got %b expected 0", i, dn_o); end
            for (int r = 0; r < 16; r++) begin
                dbg_idx = 4'(r);
                #1;
                n_checks++; if (cur_dbg !== mrd(0, r)) begin n_fail++; $display("[TB] FAIL tmo%0d R%0d: got %h expected %h", i, r, cur_dbg, mrd(0, r)); end
            end
        end
    endtask

    task automatic test_random(input int s, input int n);
        int          tmo, ra, rb, dl, lat_e, reqs_e, lat_o, reqs_o;
        logic [1:0]  op;
        logic        err_e, err_o, we_o, dn_o, rdy_o;
        logic [15:0] addr_e, addr_o;
        logic [31:0] wd_e, wd_o;
        sel = 1'(s);
        tmo = (s == 1) ? 6 : 4;
        for (int i = 0; i < n; i++) begin
            op = 2'($urandom_range(0, 3));
            ra = $urandom_range(0, 15);
            rb = $urandom_range(0, 15);
            dl = $urandom_range(0, tmo + 1);
            if (dl == tmo + 1) dl = -1;
            model_cmd(s, op, ra, rb, dl, lat_e, err_e, reqs_e, addr_e, wd_e);
            do_cmd(op, ra, rb, dl, lat_o, err_o, reqs_o, addr_o, we_o, wd_o, dn_o, rdy_o);
            n_checks++; if (lat_o != lat_e) begin n_fail++; $display("[TB] FAIL rnd%0d_%0d latency: got %0d expected %0d", s, i, lat_o, lat_e); end
            n_checks++; if (err_o !== err_e) begin n_fail++; $display("[TB] FAIL rnd%0d_%0d err: got %b expected %b", s, i, err_o, err_e); end
            n_checks++; if (reqs_o != reqs_e) begin n_fail++; $display("[TB] FAIL rnd%0d_%0d req_cycles: got %0d expected %0d", s, i, reqs_o, reqs_e); end
            n_checks++; if (dn_o !== 1'b0 || rdy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rnd%0d_%0d handshake: got done_after=%b ready=%b expected 0/1", s, i, dn_o, rdy_o); end
            if (reqs_e > 0) begin
                n_checks++; if (addr_o !== addr_e || we_o !== (op == OP_STORE)) begin n_fail++; $display("[TB] FAIL rnd%0d_%0d req: got addr=%h we=%b expected addr=%h we=%b", s, i, addr_o, we_o, addr_e, op == OP_STORE); end
                if (op == OP_STORE) begin
                    n_checks++; if (wd_o !== wd_e) begin n_fail++; $display("[TB] FAIL rnd%0d_%0d wdata: got %h expected %h", s, i, wd_o, wd_e); end
                end
            end
            for (int r = 0; r < 16; r++) begin
                dbg_idx = 4'(r);
                #1;
                n_checks++; if (cur_dbg !== mrd(s, r)) begin n_fail++; $display("[TB] FAIL rnd%0d_%0d R%0d: got %h expected %h", s, i, r, cur_dbg, mrd(s, r)); end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic seen;
        sel = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_ra    = 4'd4;
        cmd_rb    = 4'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        mem_ack   = 1'b0;
        seen      = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (cur_req) seen = 1'b1;
            else         @(negedge clk);
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset reached_req: got %b expected 1", seen); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (cur_req !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset req: got %b expected 0", cur_req); end
        n_checks++; if (cur_done !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset done: got %b expected 0", cur_done); end
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        n_checks++; if (cur_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset ready: got %b expected 1", cur_ready); end
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int r = 0; r < 16; r++) begin
                dbg_idx = 4'(r);
                #1;
                n_checks++; if (cur_dbg !== 32'h0) begin n_fail++; $display("[TB] FAIL midreset dbg[%0d][%0d]: got %h expected 0", s, r, cur_dbg); end
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_small;
        logic [1:0]  ops [7] = '{OP_LOAD, OP_MOVE, OP_MOVE, OP_CLEAR, OP_MOVE, OP_LOAD, OP_LOAD};
        int          ras [7] = '{1, 13, 1, 0, 0, 0, 11};
        int          rbs [7] = '{0, 1, 12, 0, 1, 1, 1};
        int          dls [7] = '{0, 0, 0, 0, 0, 1, 5};
        int          lat_e, reqs_e, lat_o, reqs_o;
        logic        err_e, err_o, we_o, dn_o, rdy_o;
        logic [15:0] addr_e, addr_o;
        logic [31:0] wd_e, wd_o;
        sel = 1'b1;
        for (int i = 0; i < 7; i++) begin
            model_cmd(1, ops[i], ras[i], rbs[i], dls[i], lat_e, err_e, reqs_e, addr_e, wd_e);
            do_cmd(ops[i], ras[i], rbs[i], dls[i], lat_o, err_o, reqs_o, addr_o, we_o, wd_o, dn_o, rdy_o);
            n_checks++; if (lat_o != lat_e) begin n_fail++; $display("[TB] FAIL small%0d latency: got %0d expected %0d", i, lat_o, lat_e); end
            n_checks++; if (err_o !== err_e) begin n_fail++; $display("[TB] FAIL small%0d err: got %b expected %b", i, err_o, err_e); end
            n_checks++; if (reqs_o != reqs_e) begin n_fail++; $display("[TB] FAIL small%0d req_cycles: got %0d expected %0d", i, reqs_o, reqs_e); end
            if (reqs_e > 0) begin
                n_checks++; if (addr_o !== addr_e) begin n_fail++; $display("[TB] FAIL small%0d addr: got %h expected %h", i, addr_o, addr_e); end
            end
            for (int r = 0; r < 16; r++) begin
                dbg_idx = 4'(r);
                #1;
                n_checks++; if (cur_dbg !== mrd(1, r)) begin n_fail++; $display("[TB] FAIL small%0d R%0d: got %h expected %h", i, r, cur_dbg, mrd(1, r)); end
            end
        end
    endtask

    initial begin
        sel       = 1'b0;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_ra    = 4'd0;
        cmd_rb    = 4'd0;
        dbg_idx   = 4'd0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        test_reset;
        test_directed;
        test_timeout;
        test_random(0, 40);
        test_reset_mid;
        test_small;
        test_random(1, 25);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
